// File: rtl/stream_mux_arb.sv
// N-channel valid/ready/last stream multiplexer: explicit select or round-robin,
// with packet locking and a single registered output stage.

module stream_mux_arb_lane #(
  parameter int DW  = 4,
  parameter int SW  = 2,
  parameter int IDX = 0
) (
  input  logic          rst_n,
  input  logic          can_load,
  input  logic          cand_vld,
  input  logic [SW-1:0] cand,
  input  logic          valid,
  input  logic          last,
  input  logic [DW-1:0] data,
  output logic          ready,
  output logic          xfer,
  output logic [DW-1:0] data_m,
  output logic          last_m
);
  // ready is gated by rst_n so nothing is offered while reset is held
  assign ready  = rst_n & can_load & cand_vld & (cand == SW'(IDX));
  assign xfer   = ready & valid;
  assign data_m = ready ? data : '0;
  assign last_m = ready & last;
endmodule

module stream_mux_arb #(
  parameter int NCH = 4,
  parameter int DW  = 4,
  parameter int SW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SW-1:0]     sel,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH-1:0]    in_last,
  input  logic [NCH*DW-1:0] in_data,
  output logic [NCH-1:0]    in_ready,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  output logic              out_last,
  output logic [SW-1:0]     out_chan,
  input  logic              out_ready,
  output logic              busy
);
  typedef enum logic {IDLE, LOCK} state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  state_t                  state;
  logic [SW-1:0]           lock_ch;
  logic                    lock_mode;
  logic [SW-1:0]           ptr;

  logic                    can_load;
  logic                    cand_vld;
  logic [SW-1:0]           cand;
  logic [NCH-1:0]          xfer_v;
  logic [NCH-1:0][DW-1:0]  data_m;
  logic [NCH-1:0]          last_m;
  logic                    xfer;
  beat_t                   sel_beat;
  logic                    eff_mode;
  logic [SW-1:0]           ptr_nxt;

  assign can_load = !out_valid | out_ready;

  // Candidate selection: lock wins, then explicit select, then round-robin scan from ptr.
  always_comb begin
    int j;
    cand_vld = 1'b0;
    cand     = '0;
    j        = 0;
    if (state == LOCK) begin
      cand_vld = 1'b1;
      cand     = lock_ch;
    end else if (!mode) begin
      if (int'(sel) < NCH) begin
        cand_vld = 1'b1;
        cand     = sel;
      end
    end else begin
      // scan downward so the channel closest to ptr is the last one written
      for (int k = NCH-1; k >= 0; k--) begin
        j = int'(ptr) + k;
        if (j >= NCH) j = j - NCH;
        if (in_valid[j]) begin
          cand_vld = 1'b1;
          cand     = SW'(j);
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    stream_mux_arb_lane #(.DW(DW), .SW(SW), .IDX(g)) u_lane (
      .rst_n    (rst_n),
      .can_load (can_load),
      .cand_vld (cand_vld),
      .cand     (cand),
      .valid    (in_valid[g]),
      .last     (in_last[g]),
      .data     (in_data[g*DW +: DW]),
      .ready    (in_ready[g]),
      .xfer     (xfer_v[g]),
      .data_m   (data_m[g]),
      .last_m   (last_m[g])
    );
  end

  // in_ready is one-hot, so an OR across lanes is the data mux
  always_comb begin
    sel_beat = '0;
    for (int c = 0; c < NCH; c++) begin
      sel_beat.data = sel_beat.data | data_m[c];
      sel_beat.last = sel_beat.last | last_m[c];
    end
  end

  assign xfer     = |xfer_v;
  // pointer policy follows the mode the packet was granted under
  assign eff_mode = (state == LOCK) ? lock_mode : mode;
  assign ptr_nxt  = (cand == SW'(NCH-1)) ? '0 : cand + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_beat.data;
      out_last  <= sel_beat.last;
      out_chan  <= cand;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      lock_ch   <= '0;
      lock_mode <= 1'b0;
      ptr       <= '0;
    end else begin
      if (xfer && sel_beat.last && eff_mode) ptr <= ptr_nxt;
      case (state)
        IDLE: if (xfer && !sel_beat.last) begin
          state     <= LOCK;
          busy      <= 1'b1;
          lock_ch   <= cand;
          lock_mode <= mode;
        end
        LOCK: if (xfer && sel_beat.last) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
